// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM states, default width
// and the iteration-counter width helper.
package div_seq_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the counter can hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit, then try
// to subtract the divisor using a parallel-prefix (lookahead) adder.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             quo_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quo_bit
);

    localparam int LVLS = $clog2(WIDTH);

    logic [WIDTH-1:0] shifted_lo;
    logic [WIDTH-1:0] g_all;
    logic [WIDTH-1:0] p_all;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign shifted_lo = {rem[WIDTH-2:0], quo_msb};

    // Prefix tree over the low WIDTH bits of (shifted + ~divisor); the top bit
    // of the WIDTH+1-bit trial is handled separately as rem[MSB] ^ 1 ^ carry.
    for (genvar l = 0; l <= LVLS; l++) begin : lvl
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        if (l == 0) begin : base
            assign g = shifted_lo & ~divisor;
            assign p = shifted_lo ^ ~divisor;
        end else begin : merge
            localparam int D = 1 << (l - 1);
            assign g = lvl[l-1].g | (lvl[l-1].p & {lvl[l-1].g[WIDTH-1-D:0], {D{1'b0}}});
            assign p = lvl[l-1].p & {lvl[l-1].p[WIDTH-1-D:0], {D{1'b1}}};
        end
    end

    assign g_all = lvl[LVLS].g;
    assign p_all = lvl[LVLS].p;

    // Carry-in is 1 (two's-complement subtract), so each carry is G | P.
    assign carry = {g_all | p_all, 1'b1};
    assign sum   = lvl[0].p ^ carry[WIDTH-1:0];

    // Trial is non-negative exactly when its sign bit is clear.
    assign quo_bit  = rem[WIDTH-1] ^ carry[WIDTH];
    assign rem_next = quo_bit ? sum : shifted_lo;

endmodule

// File: rtl/div_seq.sv
// Multicycle signed divider: magnitudes are divided by shift-and-subtract,
// one quotient bit per cycle, and signs are restored on the way out.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] data_quotient,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_ready,
    output logic             busy
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem_step;
    logic             quo_bit;
    logic             sign_q;
    logic             sign_r;
    logic             div_zero;
    logic             load;
    logic             step;
    logic             finish;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // |-2^(WIDTH-1)| is 2^(WIDTH-1), which fits in WIDTH bits unsigned.
    assign mag_a = data_a[WIDTH-1] ? -data_a : data_a;
    assign mag_b = data_b[WIDTH-1] ? -data_b : data_b;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .quo_msb  (quo[WIDTH-1]),
        .divisor  (divisor),
        .rem_next (rem_step),
        .quo_bit  (quo_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        if (ctrl_div) begin
            state_nxt = (data_b == '0) ? DONE : RUN;
        end else begin
            case (state)
                RUN:     if (count == LAST) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // A start pulse in any state abandons whatever is running.
    always_comb begin
        load   = ctrl_div;
        step   = (state == RUN) && !ctrl_div;
        finish = (state == DONE) && !ctrl_div;
        busy   = (state != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            count    <= '0;
            divisor  <= mag_b;
            rem      <= '0;
            quo      <= mag_a;
            sign_q   <= data_a[WIDTH-1] ^ data_b[WIDTH-1];
            sign_r   <= data_a[WIDTH-1];
            div_zero <= (data_b == '0);
        end else if (step) begin
            count <= count + CW'(1);
            rem   <= rem_step;
            quo   <= {quo[WIDTH-2:0], quo_bit};
        end
    end

    // Results are registered once in DONE and held until the next completion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_quotient  <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_ready     <= 1'b0;
        end else begin
            data_ready <= finish;
            if (finish) begin
                data_quotient  <= div_zero ? '0 : (sign_q ? -quo : quo);
                data_remainder <= sign_r ? -rem : rem;
                data_exception <= div_zero;
            end
        end
    end

    a_ready_idle: assert property (@(posedge clock) disable iff (!reset_n)
        data_ready |-> !busy);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, multi-cycle corner
// sequences and a randomized sweep against a plain signed-arithmetic model.
module tb_div_seq;

    localparam int W      = 32;
    localparam int LAT    = W + 1;
    localparam int LAT_DZ = 1;

    logic         clock    = 1'b0;
    logic         reset_n  = 1'b0;
    logic         ctrl_div = 1'b0;
    logic [W-1:0] data_a   = '0;
    logic [W-1:0] data_b   = '0;
    logic [W-1:0] data_quotient;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    div_seq #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_a         (data_a),
        .data_b         (data_b),
        .data_quotient  (data_quotient),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_ready     (data_ready),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Signed division as the ISA defines it: truncate toward zero, remainder
    // takes the dividend's sign, divide-by-zero yields zeros and a flag.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic e);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = '0;
            r = '0;
            e = 1'b1;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
            e = 1'b0;
        end
    endfunction

    // Called at a falling edge; the start pulse is sampled by the next rising edge.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        ctrl_div = 1'b1;
        data_a   = a;
        data_b   = b;
        @(negedge clock);
        ctrl_div = 1'b0;
        data_a   = $urandom;
        data_b   = $urandom;
    endtask

    // Counts rising edges after the start edge until data_ready is seen; -1 on timeout.
    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (data_ready) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic e,
                          input int lat);
        int n;
        start(a, b);
        check({tag, " busy"}, 64'(busy), 64'(1));
        wait_ready(n);
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " quotient"}, 64'(data_quotient), 64'(q));
        check({tag, " remainder"}, 64'(data_remainder), 64'(r));
        check({tag, " exception"}, 64'(data_exception), 64'(e));
        @(negedge clock);
        check({tag, " ready width"}, 64'(data_ready), 64'(0));
        check({tag, " hold"}, 64'(data_quotient), 64'(q));
        check({tag, " idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        int           seen;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, LAT};
        vecs[1] = '{-32'sd100,      32'd7,          -32'sd14,       -32'sd2,        1'b0, LAT};
        vecs[2] = '{32'd100,        -32'sd7,        -32'sd14,       32'd2,          1'b0, LAT};
        vecs[3] = '{-32'sd100,      -32'sd7,        32'd14,         -32'sd2,        1'b0, LAT};
        vecs[4] = '{32'd5,          32'd0,          32'd0,          32'd0,          1'b1, LAT_DZ};
        vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, LAT};
        vecs[6] = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, LAT};
        vecs[7] = '{32'hFFFF_FFFF,  32'd2,          32'd0,          32'hFFFF_FFFF,  1'b0, LAT};
        vecs[8] = '{32'd3,          32'd100,        32'd0,          32'd3,          1'b0, LAT};
        vecs[9] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  1'b0, LAT};

        repeat (3) @(negedge clock);
        check("reset quotient", 64'(data_quotient), 64'(0));
        check("reset remainder", 64'(data_remainder), 64'(0));
        check("reset exception", 64'(data_exception), 64'(0));
        check("reset ready", 64'(data_ready), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   vecs[i].e, vecs[i].lat);
        end

        // Back-to-back: the next start is issued in the cycle data_ready is high.
        start(32'd20, 32'd3);
        wait_ready(n);
        check("b2b first latency", 64'(n), 64'(LAT));
        check("b2b first quotient", 64'(data_quotient), 64'(6));
        start(32'd40, 32'd6);
        wait_ready(n);
        check("b2b second latency", 64'(n), 64'(LAT));
        check("b2b second quotient", 64'(data_quotient), 64'(6));
        check("b2b second remainder", 64'(data_remainder), 64'(4));
        @(negedge clock);

        // Restart mid-RUN: the first operation must never report.
        start(32'd1000, 32'd3);
        seen = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_ready) seen++;
        end
        check("restart busy", 64'(busy), 64'(1));
        start(32'd9, 32'd4);
        wait_ready(n);
        check("restart no early ready", 64'(seen), 64'(0));
        check("restart latency", 64'(n), 64'(LAT));
        check("restart quotient", 64'(data_quotient), 64'(2));
        check("restart remainder", 64'(data_remainder), 64'(1));
        @(negedge clock);

        // Restart while in DONE: the abandoned result is never published.
        start(32'd50, 32'd5);
        repeat (W) @(negedge clock);
        check("done-restart pre ready", 64'(data_ready), 64'(0));
        start(32'd21, 32'd4);
        wait_ready(n);
        check("done-restart latency", 64'(n), 64'(LAT));
        check("done-restart quotient", 64'(data_quotient), 64'(5));
        check("done-restart remainder", 64'(data_remainder), 64'(1));
        @(negedge clock);

        // Asynchronous reset in the middle of an operation.
        start(32'd12345, 32'd7);
        repeat (14) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset quotient", 64'(data_quotient), 64'(0));
        check("midreset remainder", 64'(data_remainder), 64'(0));
        check("midreset busy", 64'(busy), 64'(0));
        check("midreset ready", 64'(data_ready), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_ready || busy) seen++;
        end
        check("midreset no resume", 64'(seen), 64'(0));
        run_op("after reset 7/7", 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, LAT);

        for (int k = 0; k < 150; k++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: b = -W'($urandom_range(1, 15));
                3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : W'($urandom_range(1, 9)); end
                4: a = W'($urandom_range(0, 1000));
                5: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            ref_div(a, b, q, r, e);
            run_op($sformatf("rand%0d %0h/%0h", k, a, b), a, b, q, r, e, e ? LAT_DZ : LAT);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
